chain_relax_sequencer: RTL
==========================

# chain_relax_sequencer

Sequential controller that owns the rope/chain node position store and drives the combinational constraint-enforcement unit. On `start` it sweeps nodes 1..NODES-1 for ITERS Gauss-Seidel passes. For each node it presents the up/self/down neighbour positions, captures the enforced result, and writes it back. It sits between the host load/readback path and the constraint datapath; node 0 is the fixed anchor.

## Interface
- `WIDTH`, 32, fixed-point word width (Q16.16, two's complement)
- `NODES`, 8, chain length including anchor; ≥ 2
- `ITERS`, 4, relaxation passes per `start`; ≥ 1
- `IDX_W`, 3, node index width; ≥ clog2(NODES)
- `CLAMP_LIM`, 32'h0010_0000, magnitude limit; used only with `CHAIN_CLAMP_EN`
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: begin a run; sampled in IDLE only
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at run end
- `ld_valid` in 1: write `ld_x`/`ld_y` to node `ld_idx`; honoured only when not busy
- `ld_idx` in IDX_W: load index
- `ld_x`, `ld_y` in WIDTH: load data
- `rd_idx` in IDX_W: readback index
- `rd_x`, `rd_y` out WIDTH: registered readback of node `rd_idx`, 1-cycle latency
- `cu_up_x`, `cu_up_y`, `cu_x`, `cu_y`, `cu_down_x`, `cu_down_y` out WIDTH: registered neighbour/self positions to constraint unit
- `cu_is_last` out 1: presented node is NODES-1
- `cu_x_in`, `cu_y_in` in WIDTH: enforced result from constraint unit; combinational from `cu_*`

## Operation
- Store: NODES × (x, y) registers, all 0 on reset.
- States: IDLE, PRESENT, WRITE, DONE.
- IDLE: `start`=1 → PRESENT, node ptr=1, pass ctr=0. Other inputs have no effect on state.
- PRESENT: hold `cu_*` stable for one cycle → WRITE.
- WRITE: store `cu_x_in`/`cu_y_in` into node ptr.
  - If ptr < NODES-1: ptr+1, go to PRESENT.
  - Else if pass < ITERS-1: pass+1, ptr=1, go to PRESENT.
  - Else: go to DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `cu_*` load, on the edge entering PRESENT for node i:
  - up = node i-1
  - self = node i
  - down = node i+1, or self when i = NODES-1
  - `cu_is_last` = (i == NODES-1)
- Forwarding: when up (node i-1) is being written on that same edge, `cu_up_*` takes the written value, not the stale store value.
- Node 0 is never written by the sweep.
- `ld_valid` while busy, or with `ld_idx` ≥ NODES: ignored. `ld_valid` in IDLE coincident with `start`: the load is applied, and the run reads the loaded value.
- `start` while busy: ignored, not queued.
- Readback is valid at any time; during a run it shows in-progress values.
- Arithmetic: none internal; pure WIDTH-bit transfer, except the optional clamp.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_x`/`rd_y`=0, all `cu_*`=0, `cu_is_last`=0, state IDLE.
- Run timing for `start` sampled at edge k:
  - `busy`=1 from cycle k+1 through the final WRITE at cycle k+2·(NODES-1)·ITERS.
  - `done`=1 in cycle k+2·(NODES-1)·ITERS+1, with `busy`=0.
  - Next `start` is accepted in the cycle after `done`.
- Defaults: 14 cycles per pass, 56 cycles busy.
- `rst_n` low mid-run: immediate return to IDLE, store cleared, no `done`.

## Configuration
- `CHAIN_CLAMP_EN` defined: each written-back coordinate is saturated to [-CLAMP_LIM, +CLAMP_LIM] (signed compare).
- `CHAIN_CLAMP_EN` undefined: raw `cu_x_in`/`cu_y_in` are stored, and `CLAMP_LIM` is unused.

## Test plan
- Reset, then read all indices → every `rd_x`/`rd_y`=0; `busy`=0, `done`=0.
- Stub unit `cu_x_in`=`cu_up_x`+32'h0001_0000, `cu_y_in`=`cu_y`; NODES=8, ITERS=1, all zero, start → node i x = i·32'h0001_0000 (proves forwarding); `done` at cycle 15.
- Same stub, ITERS=4 → identical result; `done` pulses once at cycle 57; `busy` is high for 56 cycles.
- Start mid-run and `ld_valid` idx 3 ← 32'h7FFF_0000 mid-run → no restart, node 3 not overwritten by the load, one `done`.
- Assert `rst_n` low at cycle 20 of a run → outputs at reset values immediately; no `done`; a subsequent start completes normally.
- With `CHAIN_CLAMP_EN`, stub returns 32'h0100_0000 / 32'hFF00_0000 → stored 32'h0010_0000 / 32'hFFF0_0000; without the macro, raw values are stored.

Source files
------------

// File: rtl/chain_relax_sequencer.sv
// chain_relax_sequencer
// Owns the rope/chain node position store and sequences Gauss-Seidel relaxation
// passes through an external combinational constraint unit. Node 0 is the fixed
// anchor; each run sweeps nodes 1..NODES-1 ITERS times.
// Optional feature: define CHAIN_CLAMP_EN to saturate every written-back
// coordinate to [-CLAMP_LIM, +CLAMP_LIM] (signed).
module chain_relax_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               NODES     = 8,
  parameter int               ITERS     = 4,
  parameter int               IDX_W     = 3,
  parameter logic [WIDTH-1:0] CLAMP_LIM = WIDTH'(32'h0010_0000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [WIDTH-1:0] ld_x,
  input  logic [WIDTH-1:0] ld_y,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_x,
  output logic [WIDTH-1:0] rd_y,
  output logic [WIDTH-1:0] cu_up_x,
  output logic [WIDTH-1:0] cu_up_y,
  output logic [WIDTH-1:0] cu_x,
  output logic [WIDTH-1:0] cu_y,
  output logic [WIDTH-1:0] cu_down_x,
  output logic [WIDTH-1:0] cu_down_y,
  output logic             cu_is_last,
  input  logic [WIDTH-1:0] cu_x_in,
  input  logic [WIDTH-1:0] cu_y_in
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_WRITE, S_DONE} state_t;

  localparam int                PASS_W     = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IDX_W-1:0]  FIRST_NODE = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_NODE  = IDX_W'(NODES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'(ITERS - 1);

  state_t            r_state, w_state_next;
  logic [IDX_W-1:0]  r_ptr, w_ptr_next;
  logic [PASS_W-1:0] r_pass, w_pass_next;

  logic [WIDTH-1:0]  r_pos_x [NODES];
  logic [WIDTH-1:0]  r_pos_y [NODES];
  logic [WIDTH-1:0]  w_pos_x_nxt [NODES];
  logic [WIDTH-1:0]  w_pos_y_nxt [NODES];

  logic              w_sweep_wr;
  logic              w_ld_en;
  logic [WIDTH-1:0]  w_wr_x, w_wr_y;
  logic [IDX_W-1:0]  w_up_idx, w_dn_idx;
  logic              w_next_last;

  logic [WIDTH-1:0]  r_cu_up_x, r_cu_up_y, r_cu_x, r_cu_y, r_cu_dn_x, r_cu_dn_y;
  logic              r_cu_last;
  logic [WIDTH-1:0]  r_rd_x, r_rd_y;

  // State register with the node pointer and pass counter that travel with it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_pass  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_pass  <= w_pass_next;
    end
  end

  // Next-state logic: IDLE waits for start, then PRESENT/WRITE alternate per node.
  // NOTE: defaults at the top of every always_comb keep it free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_pass_next  = r_pass;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_PRESENT;
          w_ptr_next   = FIRST_NODE;
          w_pass_next  = '0;
        end
      end
      S_PRESENT: w_state_next = S_WRITE;
      S_WRITE: begin
        if (r_ptr < LAST_NODE) begin
          w_ptr_next   = r_ptr + 1'b1;
          w_state_next = S_PRESENT;
        end else if (r_pass < LAST_PASS) begin
          w_pass_next  = r_pass + 1'b1;
          w_ptr_next   = FIRST_NODE;
          w_state_next = S_PRESENT;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    w_sweep_wr = 1'b0;
    case (r_state)
      S_PRESENT: busy = 1'b1;
      S_WRITE: begin
        busy       = 1'b1;
        w_sweep_wr = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef CHAIN_CLAMP_EN
  localparam logic [WIDTH-1:0] NEG_LIM = -CLAMP_LIM;

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] v);
    if ($signed(v) > $signed(CLAMP_LIM)) return CLAMP_LIM;
    else if ($signed(v) < $signed(NEG_LIM)) return NEG_LIM;
    else return v;
  endfunction

  assign w_wr_x = sat(cu_x_in);
  assign w_wr_y = sat(cu_y_in);
`else
  assign w_wr_x = cu_x_in;
  assign w_wr_y = cu_y_in;

  // CLAMP_LIM has no role without the clamp; fold it into a deliberately unused net.
  logic w_unused_clamp;
  assign w_unused_clamp = ^CLAMP_LIM;
`endif

  // Host loads are only honoured while no sweep owns the store.
  assign w_ld_en = ld_valid && !busy && (int'(ld_idx) < NODES);

  // Post-edge view of the store: feeds the store flops and the cu_* loads,
  // so a node written on an edge is seen by a presentation loaded on that edge.
  always_comb begin
    for (int j = 0; j < NODES; j++) begin
      w_pos_x_nxt[j] = r_pos_x[j];
      w_pos_y_nxt[j] = r_pos_y[j];
      if (w_ld_en && int'(ld_idx) == j) begin
        w_pos_x_nxt[j] = ld_x;
        w_pos_y_nxt[j] = ld_y;
      end
      if (w_sweep_wr && int'(r_ptr) == j && j != 0) begin
        w_pos_x_nxt[j] = w_wr_x;
        w_pos_y_nxt[j] = w_wr_y;
      end
    end
  end

  // Node position store, cleared by reset.
  // NOTE: this is a small flop array, not a RAM macro, so a reset clear of every entry is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NODES; j++) begin
        r_pos_x[j] <= '0;
        r_pos_y[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NODES; j++) begin
        r_pos_x[j] <= w_pos_x_nxt[j];
        r_pos_y[j] <= w_pos_y_nxt[j];
      end
    end
  end

  // Neighbour indices for the node about to be presented; the last node uses itself as "down".
  assign w_next_last = (w_ptr_next == LAST_NODE);
  assign w_up_idx    = w_ptr_next - 1'b1;
  assign w_dn_idx    = w_next_last ? w_ptr_next : w_ptr_next + 1'b1;

  // Constraint-unit operand registers, loaded on every edge that enters PRESENT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cu_up_x <= '0;
      r_cu_up_y <= '0;
      r_cu_x    <= '0;
      r_cu_y    <= '0;
      r_cu_dn_x <= '0;
      r_cu_dn_y <= '0;
      r_cu_last <= 1'b0;
    end else if (w_state_next == S_PRESENT) begin
      r_cu_up_x <= w_pos_x_nxt[w_up_idx];
      r_cu_up_y <= w_pos_y_nxt[w_up_idx];
      r_cu_x    <= w_pos_x_nxt[w_ptr_next];
      r_cu_y    <= w_pos_y_nxt[w_ptr_next];
      r_cu_dn_x <= w_pos_x_nxt[w_dn_idx];
      r_cu_dn_y <= w_pos_y_nxt[w_dn_idx];
      r_cu_last <= w_next_last;
    end
  end

  // Registered readback; shows in-progress values during a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_x <= '0;
      r_rd_y <= '0;
    end else begin
      r_rd_x <= (int'(rd_idx) < NODES) ? r_pos_x[rd_idx] : '0;
      r_rd_y <= (int'(rd_idx) < NODES) ? r_pos_y[rd_idx] : '0;
    end
  end

  assign cu_up_x    = r_cu_up_x;
  assign cu_up_y    = r_cu_up_y;
  assign cu_x       = r_cu_x;
  assign cu_y       = r_cu_y;
  assign cu_down_x  = r_cu_dn_x;
  assign cu_down_y  = r_cu_dn_y;
  assign cu_is_last = r_cu_last;
  assign rd_x       = r_rd_x;
  assign rd_y       = r_rd_y;

endmodule
